vdp_host_master: RTL and testbench

Host-side initiator for the VDP CPU port. It turns queued commands into correctly timed `mode`/`csw_n`/`csr_n`/`cd` bus cycles: register write, VRAM address set, VRAM data write, and data or status read. It is the driving end of the interface that the V9958 top-level samples and synchronises. It is used for the on-board self-test/boot sequencer and as the bench stimulus source for the VDP top-level.

---
 rtl/vdp_host_master.sv | 220 ++++++++++++++++++++++
 tb/tb_vdp_host_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_master.sv
`default_nettype none
// ============================================================================
// Module      : vdp_host_master
// Description : Host-side initiator for the VDP CPU port; expands queued
//               commands into timed mode/csw_n/csr_n/cd bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_host_master #(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 8,
    parameter int RECOVER_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [13:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [1:0]  mode,
    output logic        csw_n,
    output logic        csr_n,
    output logic [7:0]  cd_o,
    output logic        cd_oe,
    input  logic [7:0]  cd_i,
    output logic        busy
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_hold    = 3'd3;
    localparam logic [2:0] c_st_recover = 3'd4;

    // Phase counters count down from N-1 to zero.
    localparam logic [7:0] c_setup_ld   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] c_pulse_ld   = 8'(PULSE_CYC - 1);
    localparam logic [7:0] c_recover_ld = 8'(RECOVER_CYC - 1);

    logic [2:0] r_state,     w_state_nx;
    logic [7:0] r_cnt,       w_cnt_nx;
    logic [7:0] r_byte1,     w_byte1_nx;
    logic       r_two,       w_two_nx;
    logic       r_second,    w_second_nx;
    logic       r_rd,        w_rd_nx;
    logic       r_ready,     w_ready_nx;
    logic [1:0] r_mode,      w_mode_nx;
    logic [7:0] r_cd_o,      w_cd_o_nx;
    logic       r_cd_oe,     w_cd_oe_nx;
    logic       r_csw_n,     w_csw_n_nx;
    logic       r_csr_n,     w_csr_n_nx;
    logic       r_rsp_valid, w_rsp_valid_nx;
    logic [7:0] r_rsp_data,  w_rsp_data_nx;

    logic [7:0] w_acc_b0;
    logic [7:0] w_acc_b1;
    logic [1:0] w_acc_mode;
    logic       w_acc_rd;
    logic       w_acc_two;

    // Byte-list expansion of the incoming command.
    always_comb begin
        w_acc_b0   = cmd_data;
        w_acc_b1   = 8'h00;
        w_acc_mode = 2'b00;
        w_acc_rd   = 1'b0;
        w_acc_two  = 1'b0;
        case (cmd_op)
            2'd0: begin
                w_acc_b1   = 8'h80 | {2'b00, cmd_addr[5:0]};
                w_acc_mode = 2'b01;
                w_acc_two  = 1'b1;
            end
            2'd1: begin
                w_acc_b0   = cmd_addr[7:0];
                w_acc_b1   = 8'h40 | {2'b00, cmd_addr[13:8]};
                w_acc_mode = 2'b01;
                w_acc_two  = 1'b1;
            end
            2'd2: begin
                w_acc_mode = 2'b00;
            end
            default: begin
                w_acc_b0   = 8'h00;
                w_acc_mode = {1'b0, cmd_addr[0]};
                w_acc_rd   = 1'b1;
            end
        endcase
    end

    // Next-state and next-output logic; every bus pin is registered from here.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_byte1_nx     = r_byte1;
        w_two_nx       = r_two;
        w_second_nx    = r_second;
        w_rd_nx        = r_rd;
        w_ready_nx     = 1'b0;
        w_mode_nx      = r_mode;
        w_cd_o_nx      = r_cd_o;
        w_cd_oe_nx     = r_cd_oe;
        w_csw_n_nx     = 1'b1;
        w_csr_n_nx     = 1'b1;
        w_rsp_valid_nx = 1'b0;
        w_rsp_data_nx  = r_rsp_data;
        case (r_state)
            c_st_idle: begin
                w_ready_nx = 1'b1;
                if (cmd_valid && r_ready) begin
                    w_state_nx  = c_st_setup;
                    w_cnt_nx    = c_setup_ld;
                    w_byte1_nx  = w_acc_b1;
                    w_two_nx    = w_acc_two;
                    w_second_nx = 1'b0;
                    w_rd_nx     = w_acc_rd;
                    w_ready_nx  = 1'b0;
                    w_mode_nx   = w_acc_mode;
                    w_cd_o_nx   = w_acc_b0;
                    w_cd_oe_nx  = ~w_acc_rd;
                end
            end
            c_st_setup: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx = c_st_strobe;
                    w_cnt_nx   = c_pulse_ld;
                    w_csw_n_nx = r_rd;
                    w_csr_n_nx = ~r_rd;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            c_st_strobe: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx     = c_st_hold;
                    w_rsp_valid_nx = r_rd;
                    if (r_rd) begin
                        w_rsp_data_nx = cd_i;
                    end
                end else begin
                    w_cnt_nx   = r_cnt - 8'd1;
                    w_csw_n_nx = r_rd;
                    w_csr_n_nx = ~r_rd;
                end
            end
            c_st_hold: begin
                w_state_nx = c_st_recover;
                w_cnt_nx   = c_recover_ld;
                w_cd_oe_nx = 1'b0;
            end
            c_st_recover: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (r_two && !r_second) begin
                    // Two-byte commands are always writes.
                    w_state_nx  = c_st_setup;
                    w_cnt_nx    = c_setup_ld;
                    w_second_nx = 1'b1;
                    w_cd_o_nx   = r_byte1;
                    w_cd_oe_nx  = 1'b1;
                end else begin
                    w_state_nx = c_st_idle;
                    w_ready_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = c_st_idle;
                w_cd_oe_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= 8'd0;
            r_byte1     <= 8'h00;
            r_two       <= 1'b0;
            r_second    <= 1'b0;
            r_rd        <= 1'b0;
            r_ready     <= 1'b0;
            r_mode      <= 2'b00;
            r_cd_o      <= 8'h00;
            r_cd_oe     <= 1'b0;
            r_csw_n     <= 1'b1;
            r_csr_n     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_byte1     <= w_byte1_nx;
            r_two       <= w_two_nx;
            r_second    <= w_second_nx;
            r_rd        <= w_rd_nx;
            r_ready     <= w_ready_nx;
            r_mode      <= w_mode_nx;
            r_cd_o      <= w_cd_o_nx;
            r_cd_oe     <= w_cd_oe_nx;
            r_csw_n     <= w_csw_n_nx;
            r_csr_n     <= w_csr_n_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_data  <= w_rsp_data_nx;
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = ~r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign mode      = r_mode;
    assign csw_n     = r_csw_n;
    assign csr_n     = r_csr_n;
    assign cd_o      = r_cd_o;
    assign cd_oe     = r_cd_oe;

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_host_master
// Description : Directed self-checking bench for vdp_host_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_cmd_valid, a_cmd_ready, a_rsp_valid, a_csw_n, a_csr_n, a_cd_oe, a_busy;
    logic [1:0]  a_cmd_op, a_mode;
    logic [13:0] a_cmd_addr;
    logic [7:0]  a_cmd_data, a_rsp_data, a_cd_o, a_cd_i;

    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_csw_n, b_csr_n, b_cd_oe, b_busy;
    logic [1:0]  b_cmd_op, b_mode;
    logic [13:0] b_cmd_addr;
    logic [7:0]  b_cmd_data, b_rsp_data, b_cd_o, b_cd_i;

    vdp_host_master u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_op(a_cmd_op), .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .mode(a_mode),
        .csw_n(a_csw_n), .csr_n(a_csr_n), .cd_o(a_cd_o), .cd_oe(a_cd_oe),
        .cd_i(a_cd_i), .busy(a_busy)
    );

    vdp_host_master #(.SETUP_CYC(1), .PULSE_CYC(1), .RECOVER_CYC(1)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_cmd_op), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .mode(b_mode),
        .csw_n(b_csw_n), .csr_n(b_csr_n), .cd_o(b_cd_o), .cd_oe(b_cd_oe),
        .cd_i(b_cd_i), .busy(b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int r_overlap = 0;
    int r_b_rsp_cnt = 0;

    always @(negedge clk) begin
        if (!a_csw_n && !a_csr_n) r_overlap++;
        if (!b_csw_n && !b_csr_n) r_overlap++;
        if (b_rsp_valid) r_b_rsp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command on the default-timing instance, checked cycle by cycle
    // against the 2/8/1/4 phase layout (offset o = 1..15 within each byte).
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [13:0] addr,
                          input logic [7:0] data, input int nb, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [1:0] em, input logic rd,
                          input logic [7:0] din);
        int bad, rv_cnt, o, bi;
        logic [7:0] eb;
        logic stb;
        bad = 0;
        rv_cnt = 0;
        a_cmd_op = op; a_cmd_addr = addr; a_cmd_data = data; a_cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 15 * nb; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_cmd_valid = 1'b0;
                a_cmd_op = ~op; a_cmd_addr = ~addr; a_cmd_data = ~data;
            end
            o   = ((k - 1) % 15) + 1;
            bi  = (k - 1) / 15;
            eb  = (bi == 0) ? b0 : b1;
            stb = (o >= 3) && (o <= 10);
            a_cd_i = (rd && stb) ? din : 8'h00;
            if (a_rsp_valid) rv_cnt++;
            if (a_cmd_ready !== 1'b0 || a_mode !== em
                || a_csw_n !== (rd || !stb) || a_csr_n !== (!rd || !stb)
                || a_cd_oe !== (!rd && o <= 11)
                || (!rd && o <= 11 && a_cd_o !== eb)
                || a_rsp_valid !== (rd && o == 11))
                bad++;
        end
        @(negedge clk);
        a_cd_i = 8'h00;
        chk({tag, "_cycles"}, bad, 0);
        chk({tag, "_ready"}, {30'd0, a_cmd_ready, a_busy}, 32'd2);
        chk({tag, "_rspcnt"}, rv_cnt, rd ? 1 : 0);
        if (rd) chk({tag, "_rspdata"}, a_rsp_data, din);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n, lows, reads, tmo, w, base;
        reset = 1'b1;
        a_cmd_valid = 0; a_cmd_op = 0; a_cmd_addr = 0; a_cmd_data = 0; a_cd_i = 0;
        b_cmd_valid = 0; b_cmd_op = 0; b_cmd_addr = 0; b_cmd_data = 0; b_cd_i = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_ready_busy", {30'd0, a_cmd_ready, a_busy}, 32'd1);
        chk("rst_strobes", {30'd0, a_csw_n, a_csr_n}, 32'd3);
        chk("rst_bus", {22'd0, a_mode, a_cd_o}, 32'd0);
        chk("rst_oe_rsp", {23'd0, a_cd_oe, a_rsp_valid, a_rsp_data}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready_low", a_cmd_ready, 0);
        @(negedge clk);
        chk("rel_ready_high", {30'd0, a_cmd_ready, a_busy}, 32'd2);
        chk("rel_no_strobe", {30'd0, a_csw_n, a_csr_n}, 32'd3);

        do_cmd("reg7",  2'd0, 14'd7,     8'hF4, 2, 8'hF4, 8'h87, 2'b01, 1'b0, 8'h00);
        do_cmd("vaddr", 2'd1, 14'h1A5C,  8'h00, 2, 8'h5C, 8'h5A, 2'b01, 1'b0, 8'h00);
        do_cmd("vdata", 2'd2, 14'h0000,  8'h3C, 1, 8'h3C, 8'h00, 2'b00, 1'b0, 8'h00);
        do_cmd("rstat", 2'd3, 14'h0001,  8'h00, 1, 8'h00, 8'h00, 2'b01, 1'b1, 8'h9F);
        do_cmd("rdata", 2'd3, 14'h0000,  8'h00, 1, 8'h00, 8'h00, 2'b00, 1'b1, 8'h21);
        do_cmd("vdata2", 2'd2, 14'h0000, 8'hA5, 1, 8'hA5, 8'h00, 2'b00, 1'b0, 8'h00);
        chk("rsp_held", a_rsp_data, 8'h21);

        // Reset in the middle of the first write strobe of a two-byte command.
        a_cmd_op = 2'd0; a_cmd_addr = 14'd3; a_cmd_data = 8'h11; a_cmd_valid = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        a_cmd_valid = 1'b0;
        chk("mid_strobe_low", a_csw_n, 0);
        reset = 1'b1;
        #1;
        chk("async_strobes", {30'd0, a_csw_n, a_csr_n}, 32'd3);
        chk("async_oe", a_cd_oe, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", a_cmd_ready, 1);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (!a_csw_n || a_rsp_valid || !a_cmd_ready) lows++;
        end
        chk("no_second_byte", lows, 0);

        // Minimum timing instance: single-byte command in 4 cycles.
        b_cmd_op = 2'd2; b_cmd_data = 8'hC3; b_cmd_valid = 1'b1;
        @(posedge clk);
        n = 0; lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            b_cmd_valid = 1'b0;
            if (b_cmd_ready) break;
            n++;
            if (!b_csw_n) begin
                lows++;
                chk("b_byte", b_cd_o, 8'hC3);
            end
        end
        chk("b_len", n, 4);
        chk("b_pulse", lows, 1);

        // Random command stream, back-to-back where possible.
        reads = 0; tmo = 0;
        base = r_b_rsp_cnt;
        for (int i = 0; i < 150; i++) begin
            w = 0;
            while (!b_cmd_ready && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!b_cmd_ready) begin
                tmo++;
                break;
            end
            b_cmd_op = 2'($urandom_range(0, 3));
            b_cmd_addr = 14'($urandom);
            b_cmd_data = 8'($urandom);
            if (b_cmd_op == 2'd3) reads++;
            b_cmd_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            b_cmd_valid = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("b_stream_timeout", tmo, 0);
        chk("b_rsp_count", r_b_rsp_cnt - base, reads);
        chk("b_ready_end", b_cmd_ready, 1);
        chk("no_overlap", r_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
